// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcode encodings and the D-channel response record used
// by the SRAM responder and its response queue.
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] A_PUTFULL    = 3'd0;
  localparam logic [2:0] A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH      = 3'd2;
  localparam logic [2:0] A_LOGICAL    = 3'd3;
  localparam logic [2:0] A_GET        = 3'd4;
  localparam logic [2:0] A_HINT       = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] D_ACCESSACK     = 3'd0;
  localparam logic [2:0] D_ACCESSACKDATA = 3'd1;
  localparam logic [2:0] D_HINTACK       = 3'd2;

  // One buffered D-channel beat
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } tl_d_resp_t;

endpackage

// File: rtl/tl_resp_queue.sv
// Small FIFO of D-channel responses. enq_ready depends only on the occupancy
// register, so there is no combinational path from deq_ready to enq_ready.
// Output bits read as zero whenever the queue is empty.
module tl_resp_queue
  import tl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enq_valid,
  output logic       enq_ready,
  input  tl_d_resp_t enq_data,
  output logic       deq_valid,
  input  logic       deq_ready,
  output tl_d_resp_t deq_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  tl_d_resp_t       slot_reg [DEPTH];

  logic enq_fire;
  logic deq_fire;

  assign enq_ready = (count_reg < DEPTH_C);
  assign deq_valid = (count_reg != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign deq_data  = deq_valid ? slot_reg[rd_ptr_reg] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clock) begin
    if (enq_fire) slot_reg[wr_ptr_reg] <= enq_data;
  end

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL manager endpoint backed by a local register-array memory.
// Decodes each accepted A beat in the acceptance cycle, performs the read or
// byte-masked write, and queues the D response so A can stream every cycle.
module tl_sram_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          ADDR_BITS   = 12,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [6:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_user_amba_prot_bufferable,
  input  logic        auto_in_a_bits_user_amba_prot_modifiable,
  input  logic        auto_in_a_bits_user_amba_prot_readalloc,
  input  logic        auto_in_a_bits_user_amba_prot_writealloc,
  input  logic        auto_in_a_bits_user_amba_prot_privileged,
  input  logic        auto_in_a_bits_user_amba_prot_secure,
  input  logic        auto_in_a_bits_user_amba_prot_fetch,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [6:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int IDX_W = ADDR_BITS - 3;
  localparam int WORDS = 2 ** IDX_W;

  logic        ready_en_reg;
  logic        q_enq_ready;
  logic        a_fire;
  logic [31:0] addr_off;
  logic        in_range;
  logic        size_ok;
  logic [2:0]  align_mask;
  logic        aligned;
  logic        legal;
  logic        is_put;
  logic        wr_en;
  logic [7:0]  byte_en;
  logic [IDX_W-1:0] word_idx;
  logic [63:0] rd_word;
  logic [63:0] mem_reg [WORDS];
  tl_d_resp_t  resp;
  tl_d_resp_t  head;
  logic        unused_prot;

  // Protection attributes are carried by the fabric but have no effect here
  assign unused_prot = ^{auto_in_a_bits_user_amba_prot_bufferable,
                         auto_in_a_bits_user_amba_prot_modifiable,
                         auto_in_a_bits_user_amba_prot_readalloc,
                         auto_in_a_bits_user_amba_prot_writealloc,
                         auto_in_a_bits_user_amba_prot_privileged,
                         auto_in_a_bits_user_amba_prot_secure,
                         auto_in_a_bits_user_amba_prot_fetch};

  // Holds a_ready low during reset and opens it on the first edge after release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ready_en_reg <= 1'b0;
    else       ready_en_reg <= 1'b1;
  end

  assign auto_in_a_ready = ready_en_reg & q_enq_ready;
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;

  // Legality: inside the region, at most 8 bytes, naturally aligned
  assign addr_off = auto_in_a_bits_address - BASE_ADDR;
  assign in_range = (auto_in_a_bits_address >= BASE_ADDR) &&
                    ((addr_off >> ADDR_BITS) == 32'd0);
  assign size_ok  = (auto_in_a_bits_size <= 3'd3);
  assign aligned  = ((auto_in_a_bits_address[2:0] & align_mask) == 3'b000);
  assign legal    = in_range & size_ok & aligned;
  assign word_idx = auto_in_a_bits_address[ADDR_BITS-1:3];

  // Low address bits that must be zero for each transfer size
  always_comb begin
    align_mask = 3'b000;
    case (auto_in_a_bits_size[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign is_put = (auto_in_a_bits_opcode == A_PUTFULL) ||
                  (auto_in_a_bits_opcode == A_PUTPARTIAL);
  assign wr_en  = a_fire & is_put & legal;

  // Per-lane write enables from the A mask
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign byte_en[gi] = wr_en & auto_in_a_bits_mask[gi];
    end
  endgenerate

  // Read sees the array before this cycle's write lands
  assign rd_word = mem_reg[word_idx];

  // Byte-masked memory write on the A fire edge; memory contents are not reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) mem_reg[word_idx][i*8 +: 8] <= auto_in_a_bits_data[i*8 +: 8];
    end
  end

  // Build the D response for the current A beat
  always_comb begin
    resp        = '0;
    resp.size   = auto_in_a_bits_size;
    resp.source = auto_in_a_bits_source;
    case (auto_in_a_bits_opcode)
      A_GET: begin
        resp.opcode = D_ACCESSACKDATA;
        if (legal) begin
          resp.data = rd_word;
        end else begin
          resp.denied  = 1'b1;
          resp.corrupt = 1'b1;
        end
      end
      A_PUTFULL, A_PUTPARTIAL: begin
        resp.opcode = D_ACCESSACK;
        resp.denied = ~legal;
      end
      A_ARITH, A_LOGICAL: begin
        resp.opcode  = D_ACCESSACKDATA;
        resp.denied  = 1'b1;
        resp.corrupt = 1'b1;
      end
      A_HINT: begin
        resp.opcode = D_HINTACK;
      end
      default: begin
        resp.opcode = D_ACCESSACK;
        resp.denied = 1'b1;
      end
    endcase
  end

  tl_resp_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_resp_queue (
    .clock    (clock),
    .reset    (reset),
    .enq_valid(auto_in_a_valid & ready_en_reg),
    .enq_ready(q_enq_ready),
    .enq_data (resp),
    .deq_valid(auto_in_d_valid),
    .deq_ready(auto_in_d_ready),
    .deq_data (head)
  );

  assign auto_in_d_bits_opcode  = head.opcode;
  assign auto_in_d_bits_size    = head.size;
  assign auto_in_d_bits_source  = head.source;
  assign auto_in_d_bits_denied  = head.denied;
  assign auto_in_d_bits_corrupt = head.corrupt;
  assign auto_in_d_bits_data    = head.data;

endmodule
